pipe_ex_mem_reg: RTL and testbench

Parametrised EX2→MEM pipeline register for the 16-bit core, the successor of the plain EX2/MEM latch. It carries the ALU result, store data, destination register and memory/writeback control across the stage boundary with a valid/ready handshake, a synchronous flush, and an optional one-entry skid buffer so MEM-stage back-pressure never drops a beat. It also exports a registered forwarding view of the MEM-stage result for the EX hazard unit.

---
 rtl/pipe_ex_mem_reg_if.sv | 38 +++
 rtl/pipe_ex_mem_reg.sv | 109 ++++++++++
 tb/tb_pipe_ex_mem_reg.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ex_mem_reg_if.sv
// rtl/pipe_ex_mem_reg_if.sv - EX2/MEM stage boundary bundle (issue, held beat, forwarding view)
interface pipe_ex_mem_reg_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_alu_out;
  logic [DATA_W-1:0] ex_rs2_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_rd;
  logic              ex_mem_wr;
  logic              ex_reg_we;
  logic              mem_valid;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_alu_out;
  logic [DATA_W-1:0] mem_rs2;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_mem_rd;
  logic              mem_mem_wr;
  logic              mem_reg_we;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;
  logic              illegal;

  modport master (
    output ex_valid, ex_alu_out, ex_rs2_data, ex_rd, ex_mem_rd, ex_mem_wr, ex_reg_we, mem_ready,
    input  ex_ready, mem_valid, mem_alu_out, mem_rs2, mem_rd, mem_mem_rd, mem_mem_wr, mem_reg_we,
    input  fwd_valid, fwd_rd, fwd_data, illegal
  );

  modport slave (
    input  ex_valid, ex_alu_out, ex_rs2_data, ex_rd, ex_mem_rd, ex_mem_wr, ex_reg_we, mem_ready,
    output ex_ready, mem_valid, mem_alu_out, mem_rs2, mem_rd, mem_mem_rd, mem_mem_wr, mem_reg_we,
    output fwd_valid, fwd_rd, fwd_data, illegal
  );
endinterface

// File: rtl/pipe_ex_mem_reg.sv
// rtl/pipe_ex_mem_reg.sv - EX2->MEM pipeline register with optional skid entry and forwarding view
module pipe_ex_mem_reg #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int SKID   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  pipe_ex_mem_reg_if.slave     bus
);
  // Payload layout: {alu_out, rs2_data, rd, mem_rd, mem_wr, reg_we}
  localparam int PW = 2 * DATA_W + REG_AW + 3;

  logic          main_v_q, main_v_d;
  logic          skid_v_q, skid_v_d;
  logic [PW-1:0] main_pl_q, main_pl_d;
  logic [PW-1:0] skid_pl_q, skid_pl_d;
  logic          illegal_q, illegal_d;

  logic          both_rw;
  logic          in_reg_we;
  logic [PW-1:0] in_pl;
  logic          ready;
  logic          accept;
  logic          consume;

  assign both_rw   = bus.ex_mem_rd & bus.ex_mem_wr;
  assign in_reg_we = bus.ex_reg_we & (bus.ex_rd != '0) & ~both_rw;
  assign in_pl     = {bus.ex_alu_out, bus.ex_rs2_data, bus.ex_rd,
                      bus.ex_mem_rd & ~both_rw, bus.ex_mem_wr & ~both_rw, in_reg_we};

  // With a skid entry, ready is purely registered so mem_ready never reaches ex_ready.
  generate
    if (SKID != 0) begin : g_ready_skid
      assign ready = ~skid_v_q;
    end else begin : g_ready_comb
      assign ready = ~main_v_q | bus.mem_ready;
    end
  endgenerate

  assign accept  = bus.ex_valid & ready & ~flush;
  assign consume = main_v_q & bus.mem_ready;

  always_comb begin
    main_v_d  = main_v_q;
    skid_v_d  = skid_v_q;
    main_pl_d = main_pl_q;
    skid_pl_d = skid_pl_q;
    illegal_d = accept & both_rw;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (consume) begin
        main_pl_d = skid_pl_q;
        skid_v_d  = 1'b0;
      end
    end else if (accept) begin
      if ((SKID != 0) && main_v_q && !consume) begin
        skid_pl_d = in_pl;
        skid_v_d  = 1'b1;
      end else begin
        main_pl_d = in_pl;
        main_v_d  = 1'b1;
      end
    end else if (consume) begin
      main_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q  <= 1'b0;
      skid_v_q  <= 1'b0;
      main_pl_q <= '0;
      skid_pl_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      main_v_q  <= main_v_d;
      skid_v_q  <= skid_v_d;
      main_pl_q <= main_pl_d;
      skid_pl_q <= skid_pl_d;
      illegal_q <= illegal_d;
    end
  end

  logic [DATA_W-1:0] h_alu;
  logic [DATA_W-1:0] h_rs2;
  logic [REG_AW-1:0] h_rd;
  logic              h_mem_rd;
  logic              h_mem_wr;
  logic              h_reg_we;

  assign {h_alu, h_rs2, h_rd, h_mem_rd, h_mem_wr, h_reg_we} = main_pl_q;

  assign bus.ex_ready    = ready;
  assign bus.mem_valid   = main_v_q;
  assign bus.mem_alu_out = h_alu;
  assign bus.mem_rs2     = h_rs2;
  assign bus.mem_rd      = h_rd;
  assign bus.mem_mem_rd  = h_mem_rd & main_v_q;
  assign bus.mem_mem_wr  = h_mem_wr & main_v_q;
  assign bus.mem_reg_we  = h_reg_we & main_v_q;
  assign bus.fwd_valid   = main_v_q & h_reg_we & ~h_mem_rd;
  assign bus.fwd_rd      = h_rd;
  assign bus.fwd_data    = h_alu;
  assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_pipe_ex_mem_reg.sv
// tb/tb_pipe_ex_mem_reg.sv - randomized bench for pipe_ex_mem_reg against a queue reference model
module tb_pipe_ex_mem_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush16 = 1'b0;
  logic flush32 = 1'b0;

  always #5 clk = ~clk;

  pipe_ex_mem_reg_if #(.DATA_W(16), .REG_AW(4)) b16 ();
  pipe_ex_mem_reg_if #(.DATA_W(32), .REG_AW(4)) b32 ();

  pipe_ex_mem_reg #(.DATA_W(16), .REG_AW(4), .SKID(1)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush16), .bus(b16.slave)
  );
  pipe_ex_mem_reg #(.DATA_W(32), .REG_AW(4), .SKID(0)) u_noskid (
    .clk(clk), .rst_n(rst_n), .flush(flush32), .bus(b32.slave)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [3:0]  rd;
    bit          mr;
    bit          mw;
    bit          we;
  } beat_t;

  int    n_cmp = 0;
  int    n_err = 0;
  int    dut   = 0;
  int    cap   = 2;
  beat_t mq[$];
  bit    ill_exp = 1'b0;

  logic [31:0] o_alu, o_rs2, o_fdata;
  logic [3:0]  o_rd, o_frd;
  logic        o_valid, o_ready, o_mr, o_mw, o_we, o_fv, o_ill;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] alu, input logic [3:0] rd,
                               input bit mr, input bit mw, input bit we);
    beat_t b;
    b.alu = alu; b.rs2 = ~alu; b.rd = rd; b.mr = mr; b.mw = mw; b.we = we;
    return b;
  endfunction

  task automatic sample();
    if (dut == 0) begin
      o_valid = b16.mem_valid;  o_ready = b16.ex_ready;
      o_alu   = {16'h0, b16.mem_alu_out}; o_rs2 = {16'h0, b16.mem_rs2}; o_rd = b16.mem_rd;
      o_mr    = b16.mem_mem_rd; o_mw = b16.mem_mem_wr; o_we = b16.mem_reg_we;
      o_fv    = b16.fwd_valid;  o_frd = b16.fwd_rd; o_fdata = {16'h0, b16.fwd_data};
      o_ill   = b16.illegal;
    end else begin
      o_valid = b32.mem_valid;  o_ready = b32.ex_ready;
      o_alu   = b32.mem_alu_out; o_rs2 = b32.mem_rs2; o_rd = b32.mem_rd;
      o_mr    = b32.mem_mem_rd; o_mw = b32.mem_mem_wr; o_we = b32.mem_reg_we;
      o_fv    = b32.fwd_valid;  o_frd = b32.fwd_rd; o_fdata = b32.fwd_data;
      o_ill   = b32.illegal;
    end
  endtask

  task automatic drive(input beat_t b, input bit v, input bit mrdy, input bit fl);
    b16.ex_valid = 1'b0; b16.mem_ready = 1'b0; flush16 = 1'b0;
    b32.ex_valid = 1'b0; b32.mem_ready = 1'b0; flush32 = 1'b0;
    if (dut == 0) begin
      b16.ex_valid = v; b16.ex_alu_out = b.alu[15:0]; b16.ex_rs2_data = b.rs2[15:0];
      b16.ex_rd = b.rd; b16.ex_mem_rd = b.mr; b16.ex_mem_wr = b.mw; b16.ex_reg_we = b.we;
      b16.mem_ready = mrdy; flush16 = fl;
    end else begin
      b32.ex_valid = v; b32.ex_alu_out = b.alu; b32.ex_rs2_data = b.rs2;
      b32.ex_rd = b.rd; b32.ex_mem_rd = b.mr; b32.ex_mem_wr = b.mw; b32.ex_reg_we = b.we;
      b32.mem_ready = mrdy; flush32 = fl;
    end
  endtask

  // One clock: drive at negedge, check against the model, advance the model at posedge.
  task automatic cycle(input beat_t b, input bit v, input bit mrdy, input bit fl);
    bit          exp_v, exp_rdy, acc, con;
    beat_t       h, s;
    logic [31:0] mask;
    mask = (dut == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    drive(b, v, mrdy, fl);
    #1;
    sample();
    exp_v   = (mq.size() != 0);
    exp_rdy = (cap == 2) ? (mq.size() < 2) : (mq.size() == 0 || mrdy);
    check("mem_valid", o_valid, exp_v);
    check("ex_ready", o_ready, exp_rdy);
    check("illegal", o_ill, ill_exp);
    if (exp_v) begin
      h = mq[0];
      check("mem_alu_out", o_alu, h.alu);
      check("mem_rs2", o_rs2, h.rs2);
      check("mem_rd", o_rd, h.rd);
      check("mem_mem_rd", o_mr, h.mr);
      check("mem_mem_wr", o_mw, h.mw);
      check("mem_reg_we", o_we, h.we);
      check("fwd_valid", o_fv, h.we && !h.mr);
      check("fwd_rd", o_frd, h.rd);
      check("fwd_data", o_fdata, h.alu);
    end else begin
      check("idle_ctl", {o_mr, o_mw, o_we, o_fv}, 4'b0000);
    end
    acc = v && exp_rdy && !fl;
    con = exp_v && mrdy;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      ill_exp = 1'b0;
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) begin
        s.alu = b.alu & mask;
        s.rs2 = b.rs2 & mask;
        s.rd  = b.rd;
        s.mr  = b.mr && !(b.mr && b.mw);
        s.mw  = b.mw && !(b.mr && b.mw);
        s.we  = b.we && (b.rd != 0) && !(b.mr && b.mw);
        mq.push_back(s);
      end
      ill_exp = acc && b.mr && b.mw;
    end
    @(negedge clk);
  endtask

  task automatic rand_cycles(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = mk($urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
      b.rs2 = $urandom;
      cycle(b, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
    end
  endtask

  beat_t nb;

  initial begin
    nb = mk(32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(nb, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    sample();
    check("rst_mem_valid", o_valid, 1'b0);
    check("rst_ex_ready", o_ready, 1'b1);
    check("rst_illegal", o_ill, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming through the skid variant
    for (int i = 1; i <= 8; i++) cycle(mk(32'(i), 4'd2, 1'b0, 1'b0, 1'b1), 1'b1, 1'b1, 1'b0);
    cycle(nb, 1'b0, 1'b1, 1'b0);

    // Back-pressure: two beats held, third refused
    cycle(mk(32'h11, 4'd1, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
    cycle(mk(32'h12, 4'd1, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
    sample();
    check("bp_full_ready", o_ready, 1'b0);
    cycle(mk(32'h13, 4'd1, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
    cycle(nb, 1'b0, 1'b1, 1'b0);
    sample();
    check("bp_drain_head", o_alu, 32'h12);
    cycle(nb, 1'b0, 1'b1, 1'b0);
    cycle(nb, 1'b0, 1'b1, 1'b0);

    // Flush while FULL with ex_valid and mem_ready both high
    cycle(mk(32'h21, 4'd1, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
    cycle(mk(32'h22, 4'd1, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
    cycle(mk(32'h99, 4'd1, 1'b0, 1'b0, 1'b1), 1'b1, 1'b1, 1'b1);
    sample();
    check("flush_valid", o_valid, 1'b0);
    check("flush_ready", o_ready, 1'b1);
    cycle(nb, 1'b0, 1'b1, 1'b0);

    // Sanitising and forwarding
    cycle(mk(32'h31, 4'd0, 1'b0, 1'b0, 1'b1), 1'b1, 1'b1, 1'b0);
    sample();
    check("r0_reg_we", o_we, 1'b0);
    check("r0_fwd_valid", o_fv, 1'b0);
    cycle(mk(32'h32, 4'd3, 1'b1, 1'b1, 1'b1), 1'b1, 1'b1, 1'b0);
    sample();
    check("ill_pulse", o_ill, 1'b1);
    check("ill_rdwr", {o_mr, o_mw, o_we}, 3'b000);
    cycle(mk(32'h33, 4'd5, 1'b1, 1'b0, 1'b1), 1'b1, 1'b1, 1'b0);
    sample();
    check("ill_once", o_ill, 1'b0);
    check("load_fwd_valid", o_fv, 1'b0);
    cycle(mk(32'hBEEF, 4'd5, 1'b0, 1'b0, 1'b1), 1'b1, 1'b1, 1'b0);
    sample();
    check("alu_fwd", {o_fv, o_frd, o_fdata[15:0]}, {1'b1, 4'd5, 16'hBEEF});
    cycle(nb, 1'b0, 1'b1, 1'b0);

    rand_cycles(400);

    // Asynchronous reset between edges while FULL
    cycle(mk(32'h41, 4'd1, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0, 1'b1);
    cycle(mk(32'h42, 4'd1, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
    cycle(mk(32'h43, 4'd1, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
    drive(nb, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    sample();
    check("arst_valid", o_valid, 1'b0);
    check("arst_ready", o_ready, 1'b1);
    mq.delete();
    ill_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SKID=0, DATA_W=32 instance
    dut = 1;
    cap = 1;
    for (int i = 1; i <= 8; i++) cycle(mk(32'(i), 4'd2, 1'b0, 1'b0, 1'b1), 1'b1, 1'b1, 1'b0);
    cycle(nb, 1'b0, 1'b1, 1'b0);
    cycle(mk(32'hCAFE_0001, 4'd7, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
    sample();
    check("ns_full_ready", o_ready, 1'b0);
    rand_cycles(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
